// File: rtl/membrane_integrator.sv
// membrane_integrator
// Integrates per-timestep synaptic currents for three neurons into leaky,
// saturating membrane potentials. A timestep closes on the beat flagged
// in_last; the block then leaks every potential once, publishes the result
// for one cycle and advances the timestep counter.
//
// Optional build macro: MEMBRANE_CLEAR_ON_INTERVAL_EN
//   defined   - potentials return to rest when an accumulation interval ends.
//   undefined - potentials carry over across intervals; only the leak decays them.
module membrane_integrator #(
    parameter int DATA_WIDTH  = 16,
    parameter int TIMER_WIDTH = 5,
    parameter int LEAK_SHIFT  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [TIMER_WIDTH-1:0]        accumulate_interval,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic signed [DATA_WIDTH-1:0]  current_0,
    input  logic signed [DATA_WIDTH-1:0]  current_1,
    input  logic signed [DATA_WIDTH-1:0]  current_2,
    output logic [DATA_WIDTH-1:0]         membrane_potential_0,
    output logic [DATA_WIDTH-1:0]         membrane_potential_1,
    output logic [DATA_WIDTH-1:0]         membrane_potential_2,
    output logic                          mp_valid,
    output logic                          interval_done,
    output logic [TIMER_WIDTH-1:0]        timestep
);

    localparam int NUM_NEURONS = 3;

    localparam logic signed [DATA_WIDTH-1:0] MP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        LEAK,
        PUBLISH
    } state_e;

    state_e                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  mp_q [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0]  mp_d [NUM_NEURONS];
    logic        [TIMER_WIDTH-1:0] ts_q, ts_d;

    logic signed [DATA_WIDTH-1:0]  cur [NUM_NEURONS];
    logic                          accept;
    logic        [TIMER_WIDTH-1:0] last_ts;

    // Add one current to a potential with one guard bit; clamp instead of wrapping.
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] sum;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            return sum[DATA_WIDTH] ? MP_MIN : MP_MAX;
        end
        return sum[DATA_WIDTH-1:0];
    endfunction

    // Leak by a fixed fraction. The arithmetic shift rounds toward -inf, so
    // subtracting it pulls negative values up toward zero; the magnitude of the
    // decrement never exceeds the value itself, so the sign never flips and the
    // subtraction cannot overflow.
    function automatic logic signed [DATA_WIDTH-1:0] leak(
        input logic signed [DATA_WIDTH-1:0] mp
    );
        if (LEAK_SHIFT == 0) begin
            return mp;
        end
        return mp - (mp >>> LEAK_SHIFT);
    endfunction

    assign cur[0] = current_0;
    assign cur[1] = current_1;
    assign cur[2] = current_2;

    assign in_ready = (state_q == IDLE) || (state_q == INTEGRATE);
    assign accept   = in_valid && in_ready;

    // An interval of 0 behaves as 1, so the last timestep index is then 0.
    assign last_ts = (accumulate_interval == '0) ? '0
                                                 : accumulate_interval - TIMER_WIDTH'(1);

    // ">=" rather than "==": if the interval is lowered below the running
    // timestep, the next publish still closes the interval and wraps to 0.
    assign mp_valid      = (state_q == PUBLISH);
    assign interval_done = (state_q == PUBLISH) && (ts_q >= last_ts);

    assign timestep             = ts_q;
    assign membrane_potential_0 = mp_q[0];
    assign membrane_potential_1 = mp_q[1];
    assign membrane_potential_2 = mp_q[2];

    // Next-state logic: integrate accepted beats, leak once, publish once.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        ts_d    = ts_q;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            mp_d[i] = mp_q[i];
        end

        unique case (state_q)
            IDLE, INTEGRATE: begin
                if (accept) begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        mp_d[i] = sat_add(mp_q[i], cur[i]);
                    end
                    state_d = in_last ? LEAK : INTEGRATE;
                end
            end

            LEAK: begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    mp_d[i] = leak(mp_q[i]);
                end
                state_d = PUBLISH;
            end

            PUBLISH: begin
                ts_d = interval_done ? '0 : ts_q + TIMER_WIDTH'(1);
`ifdef MEMBRANE_CLEAR_ON_INTERVAL_EN
                if (interval_done) begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        mp_d[i] = '0;
                    end
                end
`endif
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State, timestep and potential registers; reset discards partial sums.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the potentials are a handful of flops, not a RAM, so they are
        // reset along with the control state; sequential state uses <= only.
        if (!rstn) begin
            state_q <= IDLE;
            ts_q    <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mp_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mp_q[i] <= mp_d[i];
            end
        end
    end

endmodule

// File: tb/tb_membrane_integrator.sv
// Self-checking bench for membrane_integrator (DATA_WIDTH=16, TIMER_WIDTH=5,
// LEAK_SHIFT=4). Directed stimulus pushes hand-computed published values into
// a scoreboard queue; a monitor pops and compares on every mp_valid.
// Honours MEMBRANE_CLEAR_ON_INTERVAL_EN when the bundle is built with it.
module tb_membrane_integrator;

    localparam int DW = 16;
    localparam int TW = 5;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [TW-1:0]        accumulate_interval = TW'(4);
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_last = 1'b0;
    logic signed [DW-1:0] current_0 = '0;
    logic signed [DW-1:0] current_1 = '0;
    logic signed [DW-1:0] current_2 = '0;
    logic [DW-1:0]        membrane_potential_0;
    logic [DW-1:0]        membrane_potential_1;
    logic [DW-1:0]        membrane_potential_2;
    logic                 mp_valid;
    logic                 interval_done;
    logic [TW-1:0]        timestep;

    typedef struct {
        int mp0;
        int mp1;
        int mp2;
        int done;
        int ts;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_valid = 1'b0;

    membrane_integrator #(
        .DATA_WIDTH (DW),
        .TIMER_WIDTH(TW),
        .LEAK_SHIFT (4)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .accumulate_interval (accumulate_interval),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_last             (in_last),
        .current_0           (current_0),
        .current_1           (current_1),
        .current_2           (current_2),
        .membrane_potential_0(membrane_potential_0),
        .membrane_potential_1(membrane_potential_1),
        .membrane_potential_2(membrane_potential_2),
        .mp_valid            (mp_valid),
        .interval_done       (interval_done),
        .timestep            (timestep)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mp(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic expect_pub(input int m0, input int m1, input int m2,
                              input int done, input int ts);
        exp_t e;
        e.mp0 = m0; e.mp1 = m1; e.mp2 = m2; e.done = done; e.ts = ts;
        sb.push_back(e);
    endtask

    // Monitor: compare every published timestep against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && mp_valid) begin
            check("mp_valid_one_cycle", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                check("unexpected_mp_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pub_mp0", mp(membrane_potential_0), e.mp0);
                check("pub_mp1", mp(membrane_potential_1), e.mp1);
                check("pub_mp2", mp(membrane_potential_2), e.mp2);
                check("pub_interval_done", int'(interval_done), e.done);
                check("pub_timestep", int'(timestep), e.ts);
            end
        end
        prev_valid = rstn && mp_valid;
    end

    // All tasks start and return on a falling edge.
    task automatic reset_dut();
        rstn = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_beat(input int c0, input int c1, input int c2, input bit last);
        int n = 0;
        in_valid  = 1'b1;
        in_last   = last;
        current_0 = DW'(c0);
        current_1 = DW'(c1);
        current_2 = DW'(c2);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            check("beat_accept_timeout", 0, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Let LEAK and PUBLISH run out after a last beat.
    task automatic drain();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc_cnt;
        int stall_cnt;

        // Reset state
        reset_dut();
        check("rst_mp0", mp(membrane_potential_0), 0);
        check("rst_mp1", mp(membrane_potential_1), 0);
        check("rst_mp2", mp(membrane_potential_2), 0);
        check("rst_timestep", int'(timestep), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_mp_valid", int'(mp_valid), 0);
        check("rst_interval_done", int'(interval_done), 0);

        // in_last without in_valid must not start anything
        in_last = 1'b1;
        repeat (3) @(negedge clk);
        in_last = 1'b0;
        check("last_no_valid_ready", int'(in_ready), 1);
        check("last_no_valid_ts", int'(timestep), 0);

        // Basic timestep with latency probes
        expect_pub(150, -150, 0, 0, 0);
        send_beat(160, -160, 0, 1'b1);
        check("leak_in_ready", int'(in_ready), 0);
        check("leak_mp_valid", int'(mp_valid), 0);
        @(negedge clk);
        check("pub_in_ready", int'(in_ready), 0);
        check("pub_mp_valid", int'(mp_valid), 1);
        @(negedge clk);
        check("after_pub_mp_valid", int'(mp_valid), 0);
        check("after_pub_in_ready", int'(in_ready), 1);
        check("after_pub_ts", int'(timestep), 1);

        // Saturation both ways, multi-beat timestep
        reset_dut();
        expect_pub(30720, -30720, 15, 0, 0);
        send_beat(32000, -30000, 5, 1'b0);
        check("partial_mp0", mp(membrane_potential_0), 32000);
        send_beat(1000, -30000, 5, 1'b0);
        check("sat_hi_partial", mp(membrane_potential_0), 32767);
        check("sat_lo_partial", mp(membrane_potential_1), -32768);
        send_beat(1000, 0, 5, 1'b1);
        drain();

        // Backpressure: valid held across three single-beat timesteps
        reset_dut();
        expect_pub(15, 0, -15, 0, 0);
        expect_pub(30, 0, -29, 0, 1);
        expect_pub(44, 0, -42, 0, 2);
        acc_cnt = 0;
        stall_cnt = 0;
        in_valid = 1'b1;
        in_last = 1'b1;
        current_0 = DW'(16);
        current_1 = '0;
        current_2 = -DW'(16);
        for (int i = 0; i < 9; i++) begin
            if (in_ready) acc_cnt++;
            else stall_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        check("bp_accepts", acc_cnt, 3);
        check("bp_stall_cycles", stall_cnt, 6);
        check("bp_ts", int'(timestep), 3);

        // Interval boundary at 3 timesteps
        reset_dut();
        accumulate_interval = TW'(3);
        expect_pub(94, 0, 0, 0, 0);
        expect_pub(182, 0, 0, 0, 1);
        expect_pub(265, 0, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            send_beat(100, 0, 0, 1'b1);
            drain();
        end
        check("interval_ts_wrap", int'(timestep), 0);
`ifdef MEMBRANE_CLEAR_ON_INTERVAL_EN
        check("interval_mp0_after", mp(membrane_potential_0), 0);
        expect_pub(94, 0, 0, 0, 0);
`else
        check("interval_mp0_after", mp(membrane_potential_0), 265);
        expect_pub(343, 0, 0, 0, 0);
`endif
        send_beat(100, 0, 0, 1'b1);
        drain();

        // accumulate_interval = 0 behaves as 1
        reset_dut();
        accumulate_interval = '0;
        expect_pub(0, 30, 0, 1, 0);
`ifdef MEMBRANE_CLEAR_ON_INTERVAL_EN
        expect_pub(0, 30, 0, 1, 0);
`else
        expect_pub(0, 59, 0, 1, 0);
`endif
        for (int i = 0; i < 2; i++) begin
            send_beat(0, 32, 0, 1'b1);
            drain();
            check("int0_ts", int'(timestep), 0);
        end

        // Interval lowered below the running timestep
        reset_dut();
        accumulate_interval = TW'(4);
        expect_pub(0, 0, 0, 0, 0);
        expect_pub(0, 0, 0, 0, 1);
        expect_pub(0, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            send_beat(0, 0, 0, 1'b1);
            drain();
        end
        accumulate_interval = TW'(2);
        expect_pub(0, 0, 0, 1, 3);
        send_beat(0, 0, 0, 1'b1);
        drain();
        check("lowered_ts_wrap", int'(timestep), 0);
        accumulate_interval = TW'(4);

        // Reset while integrating
        reset_dut();
        expect_pub(0, 0, 0, 0, 0);
        send_beat(0, 0, 0, 1'b1);
        drain();
        send_beat(500, 0, 0, 1'b0);
        check("pre_rst_mp0", mp(membrane_potential_0), 500);
        check("pre_rst_ts", int'(timestep), 1);
        check("pre_rst_in_ready", int'(in_ready), 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_mp0", mp(membrane_potential_0), 0);
        check("mid_rst_ts", int'(timestep), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_mp_valid", int'(mp_valid), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        expect_pub(38, 0, 0, 0, 0);
        send_beat(40, 0, 0, 1'b1);
        drain();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/membrane_integrator.md
Name: membrane_integrator

Overview:
- Upstream neighbour of the activation unit: integrates per-timestep synaptic currents for 3 neurons into leaky membrane potentials.
- Produces the membrane_potential_0..2 values the activation unit consumes, plus a one-cycle publish strobe and an interval boundary pulse.
- Currents arrive as beats on a valid/ready stream; a timestep closes on the beat flagged in_last.

Parameters:
- DATA_WIDTH, 16, width of currents and membrane potentials (two's complement).
- TIMER_WIDTH, 5, width of the timestep counter and accumulate_interval.
- LEAK_SHIFT, 4, leak is mp >>> LEAK_SHIFT per timestep; 0 disables the leak.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- accumulate_interval  in  TIMER_WIDTH  timesteps per accumulation interval.
- in_valid  in  1  current beat valid.
- in_ready  out  1  block accepts a beat.
- in_last  in  1  accepted beat is the last of the current timestep.
- current_0..current_2  in  DATA_WIDTH signed  synaptic current per neuron.
- membrane_potential_0..membrane_potential_2  out  DATA_WIDTH  registered potentials (two's complement bits).
- mp_valid  out  1  one-cycle pulse: potentials final for this timestep.
- interval_done  out  1  one-cycle pulse, coincident with mp_valid, on the last timestep of an interval.
- timestep  out  TIMER_WIDTH  index of the timestep in progress.

Behaviour:
- Reset: state IDLE; all potentials 0; timestep 0; in_ready 1; mp_valid 0; interval_done 0.
- FSM states: IDLE, INTEGRATE, LEAK, PUBLISH.
- Acceptance: a beat is accepted when in_valid && in_ready.
- in_ready is 1 in IDLE and INTEGRATE, and 0 in LEAK and PUBLISH.
- IDLE:
  - Accepted beat with in_last=0: integrate the beat, go to INTEGRATE.
  - Accepted beat with in_last=1: integrate the beat, go to LEAK.
- INTEGRATE:
  - Each accepted beat integrates; in_last=1 goes to LEAK.
  - No beat: hold state.
- Integrate rule: mp_i <= sat(mp_i + current_i), computed at DATA_WIDTH+1 bits.
  - Saturates to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1); never wraps.
- LEAK (1 cycle):
  - mp_i <= mp_i - (mp_i >>> LEAK_SHIFT), arithmetic shift.
  - Negative values leak toward 0. Leak never changes sign and never overflows.
  - Then go to PUBLISH.
- PUBLISH (1 cycle):
  - mp_valid=1.
  - interval_done=1 iff timestep == eff_interval-1, where eff_interval = max(accumulate_interval, 1). accumulate_interval=0 therefore behaves as 1.
  - On the next edge: timestep <= interval_done ? 0 : timestep+1. Go to IDLE.
- Timestep counter never exceeds eff_interval-1.
  - If accumulate_interval is lowered below the current timestep mid-interval: interval_done fires on the next PUBLISH and timestep wraps to 0.
- Latency:
  - Beat with in_last accepted at edge N.
  - LEAK result registered at N+1.
  - mp_valid high during cycle N+1..N+2; potentials stable while mp_valid=1.
  - Next beat accepted no earlier than edge N+3.
- Outputs are driven directly from the potential registers.
  - Values during IDLE/INTEGRATE are partial sums; downstream samples only when mp_valid=1.
- in_last without in_valid is ignored. in_valid held while in_ready=0 is not consumed (no drop, no duplicate).
- rstn low mid-timestep: immediate clear of all state; partial sums discarded.

Optional Feature:
- Macro: MEMBRANE_CLEAR_ON_INTERVAL_EN.
- Defined: on the edge leaving PUBLISH with interval_done=1, all potentials clear to 0 (the next interval starts from rest).
- Not defined: potentials carry over across intervals; only leak decays them.
- mp_valid and interval_done timing are identical in both builds.

Test Plan:
- Reset release, LEAK_SHIFT=4, interval=4. One beat currents (160,-160,0) with in_last → mp_valid one cycle later with (150,-150,0), interval_done=0, timestep goes 0→1.
- Saturation: mp_0=32000, two beats current_0=+1000, last on second → mp_0 = 32767 - (32767>>>4) = 30720; no wrap to negative.
- Backpressure: in_valid held high continuously across 3 timesteps of 1 beat each → exactly 3 accepts, one every 3 cycles; in_ready=0 during LEAK/PUBLISH.
- Interval boundary: interval=3, 3 timesteps → interval_done pulses with the 3rd mp_valid, timestep returns to 0. With MEMBRANE_CLEAR_ON_INTERVAL_EN, potentials read 0 after; without, they carry over.
- accumulate_interval=0 → interval_done on every mp_valid; timestep stays 0.
- Assert rstn low while in INTEGRATE with mp_0=500 → all outputs 0, in_ready=1 immediately; next timestep integrates from 0.
